// File: rtl/controller_sequencer.sv
// SAP-1 control unit: six-state one-hot ring (T1..T6) with an opcode decoder
// that produces the 12-bit control word and the halt indication.
module controller_sequencer (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  OPCODE,
    output logic [11:0] CON,
    output logic [5:0]  T_STATE,
    output logic        HLT
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word layout: {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
    localparam logic [11:0] CON_NOP      = 12'h3E3;
    localparam logic [11:0] CON_FETCH_T1 = 12'h5E3;
    localparam logic [11:0] CON_FETCH_T2 = 12'hBE3;
    localparam logic [11:0] CON_FETCH_T3 = 12'h263;
    localparam logic [11:0] CON_MAR_IR   = 12'h1A3;
    localparam logic [11:0] CON_RAM_A    = 12'h2C3;
    localparam logic [11:0] CON_RAM_B    = 12'h2E1;
    localparam logic [11:0] CON_ADD_A    = 12'h3C7;
    localparam logic [11:0] CON_SUB_A    = 12'h3CF;
    localparam logic [11:0] CON_A_OUT    = 12'h3F2;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e state_reg, state_next;
    logic     halted_reg, halted_next;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg  <= T1;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= halted_next;
        end
    end

    assign T_STATE = state_reg;

    always_comb begin
        state_next  = state_reg;
        halted_next = halted_reg;
        CON         = CON_NOP;
        HLT         = 1'b0;
        if (CLR) begin
            // Forced NOP keeps an aborted instruction from strobing anything.
            state_next  = T1;
            halted_next = 1'b0;
        end else if (halted_reg) begin
            HLT = 1'b1;
        end else begin
            case (state_reg)
                T1: begin
                    CON        = CON_FETCH_T1;
                    state_next = T2;
                end
                T2: begin
                    CON        = CON_FETCH_T2;
                    state_next = T3;
                end
                T3: begin
                    CON        = CON_FETCH_T3;
                    state_next = T4;
                end
                T4: begin
                    state_next = T5;
                    case (OPCODE)
                        OP_LDA, OP_ADD, OP_SUB: CON = CON_MAR_IR;
                        OP_OUT:                 CON = CON_A_OUT;
                        OP_HLT: begin
                            // Ring freezes at T4 once the halt flag is set.
                            HLT         = 1'b1;
                            halted_next = 1'b1;
                            state_next  = T4;
                        end
                        default:                CON = CON_NOP;
                    endcase
                end
                T5: begin
                    state_next = T6;
                    case (OPCODE)
                        OP_LDA:         CON = CON_RAM_A;
                        OP_ADD, OP_SUB: CON = CON_RAM_B;
                        default:        CON = CON_NOP;
                    endcase
                end
                T6: begin
                    state_next = T1;
                    case (OPCODE)
                        OP_ADD:  CON = CON_ADD_A;
                        OP_SUB:  CON = CON_SUB_A;
                        default: CON = CON_NOP;
                    endcase
                end
                default: state_next = T1;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: vector table for whole instructions,
// hand sequences for halt and mid-instruction clear, plus a bus-driver monitor.
module tb_controller_sequencer;

    logic        CLK;
    logic        CLR;
    logic [3:0]  OPCODE;
    logic [11:0] CON;
    logic [5:0]  T_STATE;
    logic        HLT;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic        clr;
        logic [3:0]  op;
        logic [5:0]  t;
        logic [11:0] con;
        logic        hlt;
    } vec_t;

    vec_t vq[$];

    controller_sequencer dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .OPCODE  (OPCODE),
        .CON     (CON),
        .T_STATE (T_STATE),
        .HLT     (HLT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive inputs for one cycle, check mid-cycle, then move past the next posedge.
    task automatic step(input logic clr, input logic [3:0] op, input logic [5:0] et,
                        input logic [11:0] econ, input logic ehlt, input string name);
        CLR    = clr;
        OPCODE = op;
        #3;
        n_checks++;
        if (T_STATE !== et || CON !== econ || HLT !== ehlt) begin
            n_fail++;
            $display("FAIL %s: got T_STATE=%b CON=%h HLT=%b, expected T_STATE=%b CON=%h HLT=%b",
                     name, T_STATE, CON, HLT, et, econ, ehlt);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic clr, input logic [3:0] op, input logic [5:0] t,
                        input logic [11:0] con, input logic hlt);
        vec_t v;
        v.clr = clr; v.op = op; v.t = t; v.con = con; v.hlt = hlt;
        vq.push_back(v);
    endtask

    task automatic push_instr(input logic [3:0] op, input logic [11:0] c4,
                              input logic [11:0] c5, input logic [11:0] c6);
        push(1'b0, op, 6'b000001, 12'h5E3, 1'b0);
        push(1'b0, op, 6'b000010, 12'hBE3, 1'b0);
        push(1'b0, op, 6'b000100, 12'h263, 1'b0);
        push(1'b0, op, 6'b001000, c4,      1'b0);
        push(1'b0, op, 6'b010000, c5,      1'b0);
        push(1'b0, op, 6'b100000, c6,      1'b0);
    endtask

    // At most one of Ep, nEi(low), nCE(low), Ea, Eu may drive the bus.
    always @(negedge CLK) begin
        if (mon_en) begin
            int drivers;
            drivers = int'(CON[10]) + int'(!CON[6]) + int'(!CON[8]) + int'(CON[4]) + int'(CON[2]);
            n_checks++;
            if (drivers > 1) begin
                n_fail++;
                $display("FAIL bus_drivers: got %0d active drivers with CON=%h, expected at most 1",
                         drivers, CON);
            end
        end
    end

    initial begin
        CLR    = 1'b1;
        OPCODE = 4'h0;
        #3;
        n_checks++;
        if (CON !== 12'h3E3 || HLT !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_first: got CON=%h HLT=%b, expected CON=3e3 HLT=0", CON, HLT);
        end
        @(posedge CLK);
        #1;
        mon_en = 1'b1;

        push(1'b1, 4'h0, 6'b000001, 12'h3E3, 1'b0);
        push_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7);   // ADD
        push_instr(4'h2, 12'h1A3, 12'h2E1, 12'h3CF);   // SUB
        push_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);   // LDA
        push_instr(4'hE, 12'h3F2, 12'h3E3, 12'h3E3);   // OUT
        push_instr(4'h5, 12'h3E3, 12'h3E3, 12'h3E3);   // undefined
        push(1'b0, 4'h5, 6'b000001, 12'h5E3, 1'b0);

        foreach (vq[i])
            step(vq[i].clr, vq[i].op, vq[i].t, vq[i].con, vq[i].hlt, $sformatf("vec%0d", i));

        // Halt: ring freezes at T4, opcode changes ignored, only CLR exits.
        step(1'b0, 4'hF, 6'b000010, 12'hBE3, 1'b0, "hlt_t2");
        step(1'b0, 4'hF, 6'b000100, 12'h263, 1'b0, "hlt_t3");
        step(1'b0, 4'hF, 6'b001000, 12'h3E3, 1'b1, "hlt_t4");
        for (int k = 0; k < 20; k++)
            step(1'b0, (k < 10) ? 4'hF : 4'h1, 6'b001000, 12'h3E3, 1'b1,
                 $sformatf("halted%0d", k));
        step(1'b1, 4'h1, 6'b001000, 12'h3E3, 1'b0, "hlt_clr");
        step(1'b0, 4'h1, 6'b000001, 12'h5E3, 1'b0, "hlt_exit_t1");

        // CLR asserted in T5 of ADD aborts the instruction.
        step(1'b0, 4'h1, 6'b000010, 12'hBE3, 1'b0, "abort_t2");
        step(1'b0, 4'h1, 6'b000100, 12'h263, 1'b0, "abort_t3");
        step(1'b0, 4'h1, 6'b001000, 12'h1A3, 1'b0, "abort_t4");
        step(1'b1, 4'h1, 6'b010000, 12'h3E3, 1'b0, "abort_t5_clr");
        step(1'b0, 4'h1, 6'b000001, 12'h5E3, 1'b0, "abort_t1");
        step(1'b0, 4'h1, 6'b000010, 12'hBE3, 1'b0, "abort_t2_after");

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
